a2s_handshake_rx: RTL and testbench
===================================

A2S_HANDSHAKE_RX -- requirements
Module: a2s_handshake_rx

Interface
REQ-001 SHALL have parameter DW, default 64: data bus width in bits (DW >= 1).
REQ-002 SHALL have parameter DEPTH, default 4: receive FIFO depth in words (power of 2, DEPTH >= 2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops on Si (SYNC_STAGES >= 2).
REQ-004 SHALL have port CLK  input  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port RESET  input  1: reset, synchronous and active-high.
REQ-006 SHALL have port Si  input  1: four-phase request from the asynchronous sender; asynchronous to CLK.
REQ-007 SHALL have port So  output  1: four-phase acknowledge to the sender; registered.
REQ-008 SHALL have port Din  input  DW: bundled data, stable from before Si rises until the sender sees So high.
REQ-009 SHALL have port Dout  output  DW: head-of-FIFO word (first-word fall-through).
REQ-010 SHALL have port Dout_valid  output  1: high when the FIFO is non-empty.
REQ-011 SHALL have port Dout_ready  input  1: consumer accepts Dout when Dout_valid and Dout_ready are both high.
REQ-012 SHALL have port Occupancy  output  clog2(DEPTH+1): current number of FIFO words.
REQ-013 SHALL have port Stall  output  1: high while a request is pending and held off because the FIFO is full.
REQ-014 SHALL have port RxCount  output  32: count of accepted tokens, wraps modulo 2^32.

Function
REQ-015 SHALL pass Si through a chain of SYNC_STAGES flops; only the last stage (Si_s) is used by logic.
REQ-016 SHALL implement a two-state FSM: IDLE (So=0) and ACK (So=1).
REQ-017 In IDLE with Si_s=1 and FIFO not full, SHALL on that edge write Din into the FIFO, set So=1, increment RxCount, and go to ACK.
REQ-018 In IDLE with Si_s=1 and FIFO full, SHALL hold So=0, write nothing, and assert Stall; it SHALL proceed per REQ-017 on the first edge with FIFO not full.
REQ-019 The full test SHALL use the registered occupancy; a pop in the same cycle SHALL NOT permit a write into a full FIFO.
REQ-020 In ACK with Si_s=0, SHALL set So=0 and go to IDLE; in ACK with Si_s=1, SHALL hold.
REQ-021 In IDLE with Si_s=0, SHALL hold and write nothing.
REQ-022 Latency: So SHALL rise exactly SYNC_STAGES+1 rising edges after the first edge at which Si is sampled high, when the FIFO is not full.
REQ-023 A written word SHALL appear on Dout with Dout_valid=1 in the same cycle So first reads 1, if the FIFO was empty.
REQ-024 A pop SHALL occur on each edge with Dout_valid=1 and Dout_ready=1; Dout_ready with an empty FIFO SHALL have no effect.
REQ-025 A simultaneous write and pop SHALL leave Occupancy unchanged and preserve FIFO order.
REQ-026 FIFO read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from Occupancy (DEPTH = full, 0 = empty).
REQ-027 Exactly one FIFO write SHALL occur per complete four-phase cycle (Si up, So up, Si down, So down).

Reset
REQ-028 On RESET=1 at a rising edge: synchroniser flops=0, FSM=IDLE, So=0, Occupancy=0, Dout_valid=0, Stall=0, RxCount=0, pointers=0.
REQ-029 Dout SHALL be 0 after reset until the first write.
REQ-030 RESET asserted mid-handshake SHALL discard FIFO contents and drop So to 0; if Si is still high after reset, it SHALL be treated as a new request.

Verification
REQ-031 Single token, SYNC_STAGES=2: Si rises with Din=0xDEADBEEF_00000001, Dout_ready=0 -> So=1 after 3 edges; Dout=0xDEADBEEF_00000001, Dout_valid=1, Occupancy=1, RxCount=1; Si falls -> So=0 after 3 edges.
REQ-032 Fill to full, DEPTH=4, Dout_ready=0: 5 handshakes -> first 4 acked, Occupancy=4; 5th holds So=0 with Stall=1; one pop -> Stall=0, 5th token acked, Occupancy=4.
REQ-033 Ordering: 16 random tokens, Dout_ready toggling randomly -> Dout sequence equals Din sequence, RxCount=16, final Occupancy=0.
REQ-034 Simultaneous write and pop with Occupancy=2 -> Occupancy stays 2, next Dout is the older word.
REQ-035 Reset mid-handshake with So=1, Occupancy=3 -> next edge: So=0, Occupancy=0, Dout_valid=0, RxCount=0; Si held high -> new ack after SYNC_STAGES+1 edges.
REQ-036 RxCount wrap: force RxCount to 0xFFFFFFFF, complete one handshake -> RxCount=0.

Source files
------------

// File: rtl/a2s_handshake_rx.sv
// Four-phase asynchronous handshake receiver: synchronises the request, captures bundled
// data into a first-word-fall-through FIFO and acknowledges once the word is stored.
module a2s_handshake_rx #(
    parameter int DW          = 64,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         Si,
    output logic                         So,
    input  logic [DW-1:0]                Din,
    output logic [DW-1:0]                Dout,
    output logic                         Dout_valid,
    input  logic                         Dout_ready,
    output logic [$clog2(DEPTH+1)-1:0]   Occupancy,
    output logic                         Stall,
    output logic [31:0]                  RxCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   si_s;
    state_t                 state_q;
    logic                   so_q;
    logic                   stall_q;
    logic [31:0]            rxcount_q;

    logic [DW-1:0]          mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]          occ_q, occ_d;
    logic                   full;
    logic                   wr_en;
    logic                   rd_en;

    // Only the last synchroniser stage may feed logic; earlier stages can be metastable.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Si};
        end
    end

    assign si_s = sync_q[SYNC_STAGES-1];

    // Full uses the registered occupancy, so a same-cycle pop cannot admit a write.
    assign full  = (occ_q == FULL_OCC);
    assign wr_en = (state_q == IDLE) && si_s && !full;
    assign rd_en = (occ_q != '0) && Dout_ready;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            so_q      <= 1'b0;
            stall_q   <= 1'b0;
            rxcount_q <= '0;
        end else begin
            stall_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (si_s) begin
                        if (!full) begin
                            state_q   <= ACK;
                            so_q      <= 1'b1;
                            rxcount_q <= rxcount_q + 32'd1;
                        end else begin
                            stall_q <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    if (!si_s) begin
                        state_q <= IDLE;
                        so_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    so_q    <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        occ_d    = occ_q;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en && !RESET) begin
            mem_q[wr_ptr_q] <= Din;
        end
    end

    // Storage is not reset; masking keeps Dout at zero whenever nothing is held.
    assign Dout_valid = (occ_q != '0);
    assign Dout       = Dout_valid ? mem_q[rd_ptr_q] : '0;
    assign So         = so_q;
    assign Stall      = stall_q;
    assign RxCount    = rxcount_q;
    assign Occupancy  = occ_q;

endmodule

// File: tb/tb_a2s_handshake_rx.sv
// Self-checking bench for a2s_handshake_rx: vector table for the fill sequence, hand-written
// corner cases, and a scoreboard queue that checks every popped word against sent tokens.
module tb_a2s_handshake_rx;

    logic        CLK;
    logic        RESET;
    logic        Si;
    logic        So;
    logic [63:0] Din;
    logic [63:0] Dout;
    logic        Dout_valid;
    logic        Dout_ready;
    logic [2:0]  Occupancy;
    logic        Stall;
    logic [31:0] RxCount;

    a2s_handshake_rx #(.DW(64), .DEPTH(4), .SYNC_STAGES(2)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Si         (Si),
        .So         (So),
        .Din        (Din),
        .Dout       (Dout),
        .Dout_valid (Dout_valid),
        .Dout_ready (Dout_ready),
        .Occupancy  (Occupancy),
        .Stall      (Stall),
        .RxCount    (RxCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] din;
        logic [63:0] exp_occ;
        logic [63:0] exp_rx;
        logic [63:0] exp_head;
    } vec_t;

    int          total;
    int          bad;
    logic [63:0] exp_q[$];
    bit          rand_ready;
    vec_t        vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock; pops seen at the edge are compared against the scoreboard.
    task automatic tick();
        logic        pop;
        logic [63:0] word;
        logic [63:0] exp;
        pop  = Dout_valid && Dout_ready && !RESET;
        word = Dout;
        @(posedge CLK);
        #1;
        if (pop) begin
            $display("pop %h", word);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", word, 64'h0);
                if (word == 64'h0) begin
                    bad++;
                    $display("FAIL sb_unexpected_pop: got pop expected none");
                end
            end else begin
                exp = exp_q.pop_front();
                check("dout_order", word, exp);
            end
        end
        if (rand_ready) Dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_so(input logic val, input int bound, output int n);
        n = 0;
        while (So !== val && n < bound) begin
            tick();
            n++;
        end
        if (So !== val) check("so_timeout", {63'h0, So}, {63'h0, val});
    endtask

    task automatic raise_req(input logic [63:0] data, output int n);
        Din = data;
        Si  = 1'b1;
        exp_q.push_back(data);
        wait_so(1'b1, 40, n);
    endtask

    task automatic drop_req(output int n);
        Si = 1'b0;
        wait_so(1'b0, 40, n);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain();
        int n;
        Dout_ready = 1'b1;
        n = 0;
        while (Dout_valid && n < 20) begin
            tick();
            n++;
        end
        Dout_ready = 1'b0;
        check("drain_occ", 64'(Occupancy), 64'd0);
        check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        logic [63:0] tok;
        total      = 0;
        bad        = 0;
        rand_ready = 1'b0;
        RESET      = 1'b1;
        Si         = 1'b0;
        Din        = '0;
        Dout_ready = 1'b0;

        vecs[0] = '{din: 64'h1111_0000_0000_00A0, exp_occ: 1, exp_rx: 1, exp_head: 64'h1111_0000_0000_00A0};
        vecs[1] = '{din: 64'h2222_0000_0000_00B1, exp_occ: 2, exp_rx: 2, exp_head: 64'h1111_0000_0000_00A0};
        vecs[2] = '{din: 64'h3333_0000_0000_00C2, exp_occ: 3, exp_rx: 3, exp_head: 64'h1111_0000_0000_00A0};
        vecs[3] = '{din: 64'h4444_0000_0000_00D3, exp_occ: 4, exp_rx: 4, exp_head: 64'h1111_0000_0000_00A0};

        // Reset state
        do_reset();
        check("rst_so", {63'h0, So}, 64'd0);
        check("rst_valid", {63'h0, Dout_valid}, 64'd0);
        check("rst_occ", 64'(Occupancy), 64'd0);
        check("rst_stall", {63'h0, Stall}, 64'd0);
        check("rst_rx", 64'(RxCount), 64'd0);
        check("rst_dout", Dout, 64'd0);

        // Single token with exact latency
        raise_req(64'hDEADBEEF_00000001, n);
        check("single_rise_lat", 64'(n), 64'd3);
        check("single_dout", Dout, 64'hDEADBEEF_00000001);
        check("single_valid", {63'h0, Dout_valid}, 64'd1);
        check("single_occ", 64'(Occupancy), 64'd1);
        check("single_rx", 64'(RxCount), 64'd1);
        drop_req(n);
        check("single_fall_lat", 64'(n), 64'd3);
        drain();

        // Fill to full from the vector table
        do_reset();
        for (int i = 0; i < 4; i++) begin
            raise_req(vecs[i].din, n);
            check($sformatf("fill%0d_lat", i), 64'(n), 64'd3);
            check($sformatf("fill%0d_occ", i), 64'(Occupancy), vecs[i].exp_occ);
            check($sformatf("fill%0d_rx", i), 64'(RxCount), vecs[i].exp_rx);
            check($sformatf("fill%0d_head", i), Dout, vecs[i].exp_head);
            drop_req(n);
        end

        // Fifth token stalls while full
        Din = 64'h5555_0000_0000_00E4;
        Si  = 1'b1;
        exp_q.push_back(Din);
        for (int i = 0; i < 8; i++) tick();
        check("full_so_held", {63'h0, So}, 64'd0);
        check("full_stall", {63'h0, Stall}, 64'd1);
        check("full_occ", 64'(Occupancy), 64'd4);
        check("full_rx", 64'(RxCount), 64'd4);
        Dout_ready = 1'b1;
        tick();
        Dout_ready = 1'b0;
        check("pop_edge_no_write_so", {63'h0, So}, 64'd0);
        check("pop_edge_occ", 64'(Occupancy), 64'd3);
        tick();
        check("unstall_so", {63'h0, So}, 64'd1);
        check("unstall_stall", {63'h0, Stall}, 64'd0);
        check("unstall_occ", 64'(Occupancy), 64'd4);
        check("unstall_rx", 64'(RxCount), 64'd5);
        drop_req(n);
        drain();

        // Simultaneous write and pop at occupancy 2
        raise_req(64'hAAAA_0000_0000_0001, n);
        drop_req(n);
        raise_req(64'hBBBB_0000_0000_0002, n);
        drop_req(n);
        check("simul_pre_occ", 64'(Occupancy), 64'd2);
        Din = 64'hCCCC_0000_0000_0003;
        Si  = 1'b1;
        exp_q.push_back(Din);
        tick();
        tick();
        Dout_ready = 1'b1;
        tick();
        Dout_ready = 1'b0;
        check("simul_so", {63'h0, So}, 64'd1);
        check("simul_occ", 64'(Occupancy), 64'd2);
        check("simul_next_dout", Dout, 64'hBBBB_0000_0000_0002);
        drop_req(n);
        drain();

        // Ordering with random back-pressure
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tok = {$urandom, $urandom};
            raise_req(tok, n);
            drop_req(n);
        end
        rand_ready = 1'b0;
        drain();
        check("order_rx", 64'(RxCount), 64'd16);

        // Reset mid-handshake with So high and three words held
        do_reset();
        raise_req(64'h0000_0001_0000_0001, n);
        drop_req(n);
        raise_req(64'h0000_0002_0000_0002, n);
        drop_req(n);
        raise_req(64'h0000_0003_0000_0003, n);
        check("midrst_pre_so", {63'h0, So}, 64'd1);
        check("midrst_pre_occ", 64'(Occupancy), 64'd3);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        exp_q.delete();
        check("midrst_so", {63'h0, So}, 64'd0);
        check("midrst_occ", 64'(Occupancy), 64'd0);
        check("midrst_valid", {63'h0, Dout_valid}, 64'd0);
        check("midrst_rx", 64'(RxCount), 64'd0);
        exp_q.push_back(Din);
        wait_so(1'b1, 40, n);
        check("midrst_reack_lat", 64'(n), 64'd3);
        check("midrst_reack_rx", 64'(RxCount), 64'd1);
        drop_req(n);
        drain();

        // RxCount wraps modulo 2^32
        force dut.rxcount_q = 32'hFFFF_FFFF;
        #1;
        release dut.rxcount_q;
        tick();
        check("wrap_pre_rx", 64'(RxCount), 64'hFFFF_FFFF);
        raise_req(64'h0000_0000_CAFE_F00D, n);
        check("wrap_rx", 64'(RxCount), 64'd0);
        drop_req(n);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
